rle_enc_param: RTL and testbench
================================

Name: rle_enc_param

Overview:
Parametrised run-length encoder and successor to the fixed 8-bit encoder between the HPS-fed input FIFO and the result FIFO.
- Symbol width and run-count width are generics.
- Runs longer than the count field allows are split across several output words.
- The last word of a stream carries an explicit last flag.
- An empty stream produces a defined terminator word.
- Symbols-in and runs-out statistics counters are readable through PIOs.

Parameters:
DATA_W, 8, symbol width in bits (>=1)
CNT_W, 16, run-count field width in bits (>=2); MAX_RUN = 2^CNT_W - 1
STAT_W, 32, width of the statistics counters

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst_n  in  1  asynchronous active-low reset
recv_ready  in  1  input FIFO not empty; in_data is valid (show-ahead FIFO)
in_data  in  DATA_W  head symbol of the input FIFO
rd_req  out  1  pops the input FIFO this cycle; symbol consumed this cycle
send_ready  in  1  output FIFO not full
wr_req  out  1  pushes out_data/out_last this cycle
out_data  out  CNT_W+DATA_W  {count, symbol}; count in the MSBs
out_last  out  1  marks the final word of a stream
end_of_stream  in  1  level flush request from PIO
done  out  1  stream finished, final word written
symbols_in  out  STAT_W  symbols consumed since the last clear
runs_out  out  STAT_W  words written since the last clear

Behaviour:
Clock, reset and output timing:
- Single clock domain; rst_n is asynchronous and active-low.
- Internal registers: state, cur_sym[DATA_W], cur_cnt[CNT_W], symbols_in, runs_out.
- rd_req, wr_req, out_last and done are combinational from registers and the current inputs.
- out_data = {cur_cnt, cur_sym} at all times.

Reset (rst_n low, asynchronous):
- state=IDLE; cur_sym=0; cur_cnt=0; counters=0.
- Therefore rd_req=0, wr_req=0, out_last=0, done=0, out_data=0.
- Reset mid-run discards the open run with no write.

States:
IDLE (no open run, cur_cnt=0, cur_sym=0):
- If recv_ready=1: rd_req=1; load cur_sym=in_data, cur_cnt=1; go to RUN.
- Else if end_of_stream=1 and send_ready=1: wr_req=1, out_last=1 (terminator word {0,0}); go to DONE.
- Input has priority over flush.
RUN, with recv_ready=1 and in_data==cur_sym and cur_cnt<MAX_RUN:
- rd_req=1; cur_cnt+1; no write.
RUN, with recv_ready=1 and (in_data!=cur_sym or cur_cnt==MAX_RUN):
- If send_ready=1: wr_req=1 (current run written, out_last=0) and rd_req=1 in the same cycle; cur_sym=in_data, cur_cnt=1.
- If send_ready=0: rd_req=0, wr_req=0, all registers hold (stall). No data loss and no duplicate write.
RUN, with recv_ready=0 and end_of_stream=1:
- If send_ready=1: wr_req=1, out_last=1; clear cur_sym and cur_cnt; go to DONE.
- Otherwise hold.
RUN, with recv_ready=0 and end_of_stream=0:
- Hold; the run stays open indefinitely.
DONE:
- done=1; rd_req=0; wr_req=0; counters hold.
- When end_of_stream=0: go to IDLE and clear both counters in the same edge.

Arithmetic and boundary rules:
- cur_cnt never wraps. A run of N symbols produces floor(N/MAX_RUN) words of count MAX_RUN, plus one word of count N mod MAX_RUN if that remainder is nonzero.
- A word with count 0 appears only as the empty-stream terminator.
- symbols_in increments on every rd_req cycle; runs_out increments on every wr_req cycle. Both wrap modulo 2^STAT_W.
- Exactly one write carries out_last=1 per stream.
- Simultaneous write-and-consume counts one symbol and one run in the same cycle.
- end_of_stream asserted while recv_ready=1 has no effect until the input FIFO drains.
- end_of_stream held high continuously after DONE does not restart the encoder.

Test Plan:
1. DATA_W=8, CNT_W=16; input AA,AA,AA,55, then end_of_stream=1 -> writes 0x0003AA (last=0), then 0x000155 (last=1); done=1; symbols_in=4; runs_out=2.
2. CNT_W=4 (MAX_RUN=15); twenty 0x11 symbols, then flush -> writes 0xF11 (last=0), then 0x511 (last=1); runs_out=2.
3. Stream AA,AA,BB with send_ready=0 when BB is at the head -> rd_req=0 and cur_cnt holds at 2 for all stall cycles; on send_ready=1, same cycle wr_req=1 with 0x0002AA and rd_req=1; stream then flushes 0x0001BB last.
4. Empty stream: end_of_stream=1, recv_ready=0 from IDLE -> single write out_data=0, out_last=1; done=1; symbols_in=0; runs_out=1.
5. rst_n pulsed low mid-run (cur_cnt=7) -> outputs go to 0 asynchronously with no write; a fresh stream CC,CC + flush afterwards yields 0x0002CC last.
6. After DONE, drop end_of_stream -> next clk edge: done=0, symbols_in=0, runs_out=0, state IDLE; keeping end_of_stream high in DONE for 10 cycles produces no writes.

Source files
------------

// File: rtl/rle_enc_param.sv
//------------------------------------------------------------------------------
// rle_enc_param : parametrised run-length encoder, show-ahead FIFO in, {count,symbol} words out
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rle_enc_param #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    parameter int STAT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    recv_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    rd_req,
    input  logic                    send_ready,
    output logic                    wr_req,
    output logic [CNT_W+DATA_W-1:0] out_data,
    output logic                    out_last,
    input  logic                    end_of_stream,
    output logic                    done,
    output logic [STAT_W-1:0]       symbols_in,
    output logic [STAT_W-1:0]       runs_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  MAX_RUN  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   cur_sym_q, cur_sym_d;
    logic [CNT_W-1:0]    cur_cnt_q, cur_cnt_d;
    logic [STAT_W-1:0]   symbols_in_q, symbols_in_d;
    logic [STAT_W-1:0]   runs_out_q, runs_out_d;
    logic                clear_stats;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_sym_q    <= '0;
            cur_cnt_q    <= '0;
            symbols_in_q <= '0;
            runs_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            cur_sym_q    <= cur_sym_d;
            cur_cnt_q    <= cur_cnt_d;
            symbols_in_q <= symbols_in_d;
            runs_out_q   <= runs_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_sym_d   = cur_sym_q;
        cur_cnt_d   = cur_cnt_q;
        rd_req      = 1'b0;
        wr_req      = 1'b0;
        out_last    = 1'b0;
        done        = 1'b0;
        clear_stats = 1'b0;
        case (state_q)
            IDLE: begin
                // Pending input always wins over a flush request.
                if (recv_ready) begin
                    rd_req    = 1'b1;
                    cur_sym_d = in_data;
                    cur_cnt_d = CNT_ONE;
                    state_d   = RUN;
                end else if (end_of_stream && send_ready) begin
                    wr_req   = 1'b1;
                    out_last = 1'b1;
                    state_d  = DONE;
                end
            end
            RUN: begin
                if (recv_ready) begin
                    if ((in_data == cur_sym_q) && (cur_cnt_q != MAX_RUN)) begin
                        rd_req    = 1'b1;
                        cur_cnt_d = cur_cnt_q + CNT_ONE;
                    end else if (send_ready) begin
                        // Emit the closed run and open the next one on the same edge.
                        wr_req    = 1'b1;
                        rd_req    = 1'b1;
                        cur_sym_d = in_data;
                        cur_cnt_d = CNT_ONE;
                    end
                end else if (end_of_stream && send_ready) begin
                    wr_req    = 1'b1;
                    out_last  = 1'b1;
                    cur_sym_d = '0;
                    cur_cnt_d = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!end_of_stream) begin
                    clear_stats = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                cur_sym_d = '0;
                cur_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        symbols_in_d = symbols_in_q;
        runs_out_d   = runs_out_q;
        if (clear_stats) begin
            symbols_in_d = '0;
            runs_out_d   = '0;
        end else begin
            if (rd_req) symbols_in_d = symbols_in_q + STAT_ONE;
            if (wr_req) runs_out_d   = runs_out_q + STAT_ONE;
        end
    end

    assign out_data   = {cur_cnt_q, cur_sym_q};
    assign symbols_in = symbols_in_q;
    assign runs_out   = runs_out_q;

endmodule

`default_nettype wire

// File: tb/tb_rle_enc_param.sv
// Testbench for rle_enc_param: FIFO model drives two instances (CNT_W=16 and CNT_W=4),
// a scoreboard checks every written word.
`default_nettype none
`timescale 1ns/1ps

module tb_rle_enc_param;

    localparam int DW  = 8;
    localparam int CWA = 16;
    localparam int CWB = 4;
    localparam int SW  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               recv_ready_a = 1'b0, send_ready_a = 1'b1, eos_a = 1'b0;
    logic [DW-1:0]      in_data_a = '0;
    logic               rd_req_a, wr_req_a, out_last_a, done_a;
    logic [CWA+DW-1:0]  out_data_a;
    logic [SW-1:0]      sym_a, runs_a;

    logic               recv_ready_b = 1'b0, send_ready_b = 1'b1, eos_b = 1'b0;
    logic [DW-1:0]      in_data_b = '0;
    logic               rd_req_b, wr_req_b, out_last_b, done_b;
    logic [CWB+DW-1:0]  out_data_b;
    logic [SW-1:0]      sym_b, runs_b;

    rle_enc_param #(.DATA_W(DW), .CNT_W(CWA), .STAT_W(SW)) dut_a (
        .clk(clk), .rst_n(rst_n), .recv_ready(recv_ready_a), .in_data(in_data_a),
        .rd_req(rd_req_a), .send_ready(send_ready_a), .wr_req(wr_req_a),
        .out_data(out_data_a), .out_last(out_last_a), .end_of_stream(eos_a),
        .done(done_a), .symbols_in(sym_a), .runs_out(runs_a)
    );

    rle_enc_param #(.DATA_W(DW), .CNT_W(CWB), .STAT_W(SW)) dut_b (
        .clk(clk), .rst_n(rst_n), .recv_ready(recv_ready_b), .in_data(in_data_b),
        .rd_req(rd_req_b), .send_ready(send_ready_b), .wr_req(wr_req_b),
        .out_data(out_data_b), .out_last(out_last_b), .end_of_stream(eos_b),
        .done(done_b), .symbols_in(sym_b), .runs_out(runs_b)
    );

    logic [DW-1:0]      fifo_a[$];
    logic [DW-1:0]      fifo_b[$];
    logic [CWA+DW:0]    exp_a[$];
    logic [CWB+DW:0]    exp_b[$];
    bit                 pend_a = 1'b0, pend_b = 1'b0;
    int                 errors = 0;
    int                 checks = 0;

    // Scoreboard: every write is compared against the oldest expected {last, data}.
    always @(negedge clk) begin
        logic [CWA+DW:0] ea;
        logic [CWB+DW:0] eb;
        pend_a = rd_req_a;
        pend_b = rd_req_b;
        if (wr_req_a) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL wr_a_extra: got data=%h last=%b, required no write", out_data_a, out_last_a);
            end else begin
                ea = exp_a.pop_front();
                if ({out_last_a, out_data_a} !== ea) begin
                    errors++;
                    $display("FAIL wr_a_word: got last=%b data=%h, required last=%b data=%h",
                             out_last_a, out_data_a, ea[CWA+DW], ea[CWA+DW-1:0]);
                end
            end
        end
        if (wr_req_b) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL wr_b_extra: got data=%h last=%b, required no write", out_data_b, out_last_b);
            end else begin
                eb = exp_b.pop_front();
                if ({out_last_b, out_data_b} !== eb) begin
                    errors++;
                    $display("FAIL wr_b_word: got last=%b data=%h, required last=%b data=%h",
                             out_last_b, out_data_b, eb[CWB+DW], eb[CWB+DW-1:0]);
                end
            end
        end
    end

    // Show-ahead input FIFO models.
    always @(posedge clk) begin
        #1;
        if (pend_a && fifo_a.size() > 0) void'(fifo_a.pop_front());
        if (pend_b && fifo_b.size() > 0) void'(fifo_b.pop_front());
        pend_a = 1'b0;
        pend_b = 1'b0;
        recv_ready_a = (fifo_a.size() != 0);
        in_data_a    = (fifo_a.size() != 0) ? fifo_a[0] : '0;
        recv_ready_b = (fifo_b.size() != 0);
        in_data_b    = (fifo_b.size() != 0) ? fifo_b[0] : '0;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({rd_req_a, wr_req_a, out_last_a, done_a, out_data_a, sym_a, runs_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: got rd=%b wr=%b last=%b done=%b data=%h sym=%0d runs=%0d, required all 0",
                     rd_req_a, wr_req_a, out_last_a, done_a, out_data_a, sym_a, runs_a);
        end
        checks++;
        if ({rd_req_b, wr_req_b, out_last_b, done_b, out_data_b, sym_b, runs_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: got rd=%b wr=%b done=%b data=%h, required all 0",
                     rd_req_b, wr_req_b, done_b, out_data_b);
        end
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (done_a !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done=%b, required 1", tag, done_a);
        end
    endtask

    task automatic finish_stream_a(input string tag);
        tick(1);
        eos_a = 1'b0;
        tick(1);
        checks++;
        if ({done_a, sym_a, runs_a} !== '0 || exp_a.size() != 0) begin
            errors++;
            $display("FAIL %s_clear: done=%b sym=%0d runs=%0d pending=%0d, required 0 0 0 0",
                     tag, done_a, sym_a, runs_a, exp_a.size());
        end
    endtask

    task automatic test_basic_stream;
        fifo_a.push_back(8'hAA); fifo_a.push_back(8'hAA);
        fifo_a.push_back(8'hAA); fifo_a.push_back(8'h55);
        exp_a.push_back({1'b0, 24'h0003AA});
        exp_a.push_back({1'b1, 24'h000155});
        tick(1);
        eos_a = 1'b1;
        wait_done_a("basic");
        checks++;
        if (sym_a !== 32'd4 || runs_a !== 32'd2) begin
            errors++;
            $display("FAIL basic_stats: sym=%0d runs=%0d, required 4 2", sym_a, runs_a);
        end
        finish_stream_a("basic");
    endtask

    task automatic test_split_run;
        int n = 0;
        for (int i = 0; i < 20; i++) fifo_b.push_back(8'h11);
        exp_b.push_back({1'b0, 12'hF11});
        exp_b.push_back({1'b1, 12'h511});
        tick(1);
        eos_b = 1'b1;
        while (done_b !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_b !== 1'b1 || sym_b !== 32'd20 || runs_b !== 32'd2 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL split_stats: done=%b sym=%0d runs=%0d pending=%0d, required 1 20 2 0",
                     done_b, sym_b, runs_b, exp_b.size());
        end
        tick(1);
        eos_b = 1'b0;
        tick(1);
    endtask

    task automatic test_stall;
        send_ready_a = 1'b0;
        fifo_a.push_back(8'hAA); fifo_a.push_back(8'hAA); fifo_a.push_back(8'hBB);
        exp_a.push_back({1'b0, 24'h0002AA});
        exp_a.push_back({1'b1, 24'h0001BB});
        tick(4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rd_req_a !== 1'b0 || wr_req_a !== 1'b0 || out_data_a !== 24'h0002AA) begin
                errors++;
                $display("FAIL stall_hold: rd=%b wr=%b data=%h, required 0 0 0002aa",
                         rd_req_a, wr_req_a, out_data_a);
            end
        end
        tick(1);
        send_ready_a = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_req_a !== 1'b1 || wr_req_a !== 1'b1 || out_data_a !== 24'h0002AA) begin
            errors++;
            $display("FAIL stall_release: rd=%b wr=%b data=%h, required 1 1 0002aa",
                     rd_req_a, wr_req_a, out_data_a);
        end
        tick(1);
        eos_a = 1'b1;
        wait_done_a("stall");
        checks++;
        if (sym_a !== 32'd3 || runs_a !== 32'd2) begin
            errors++;
            $display("FAIL stall_stats: sym=%0d runs=%0d, required 3 2", sym_a, runs_a);
        end
        finish_stream_a("stall");
    endtask

    task automatic test_empty_and_hold;
        int writes = 0;
        exp_a.push_back({1'b1, 24'h000000});
        eos_a = 1'b1;
        wait_done_a("empty");
        checks++;
        if (sym_a !== 32'd0 || runs_a !== 32'd1) begin
            errors++;
            $display("FAIL empty_stats: sym=%0d runs=%0d, required 0 1", sym_a, runs_a);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr_req_a || !done_a) writes++;
        end
        checks++;
        if (writes != 0 || runs_a !== 32'd1) begin
            errors++;
            $display("FAIL hold_done: bad cycles=%0d runs=%0d, required 0 1", writes, runs_a);
        end
        finish_stream_a("empty");
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 7; i++) fifo_a.push_back(8'h77);
        tick(10);
        checks++;
        if (out_data_a !== 24'h000777 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre: data=%h done=%b, required 000777 0", out_data_a, done_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_data_a, rd_req_a, wr_req_a, out_last_a, done_a, sym_a, runs_a} !== '0) begin
            errors++;
            $display("FAIL rst_async: data=%h rd=%b wr=%b sym=%0d runs=%0d, required all 0",
                     out_data_a, rd_req_a, wr_req_a, sym_a, runs_a);
        end
        tick(2);
        rst_n = 1'b1;
        fifo_a.push_back(8'hCC); fifo_a.push_back(8'hCC);
        exp_a.push_back({1'b1, 24'h0002CC});
        tick(1);
        eos_a = 1'b1;
        wait_done_a("rst");
        checks++;
        if (sym_a !== 32'd2 || runs_a !== 32'd1) begin
            errors++;
            $display("FAIL rst_stats: sym=%0d runs=%0d, required 2 1", sym_a, runs_a);
        end
        finish_stream_a("rst");
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_split_run();
        test_stall();
        test_empty_and_hold();
        test_async_reset();
        tick(2);
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending a=%0d b=%0d, required 0 0", exp_a.size(), exp_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
